fault_inject_ctrl: RTL and testbench

FAULT_INJECT_CTRL -- requirements
Module: fault_inject_ctrl

---
 rtl/fault_inject_ctrl.sv | 172 +++++++++++++++++
 tb/tb_fault_inject_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_inject_ctrl.sv
// Fault injection controller: sits between an upstream register and its
// downstream consumer, and corrupts one bit of the passing value during a
// programmed window of a run.
//
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   start_i           request a new run (accepted in IDLE or DONE only)
//   tgt_cycle_i       run-relative cycle where the fault begins
//   tgt_bit_i         bit of sig_in_i to corrupt
//   fault_type_i      0 none, 1 transient flip, 2 stuck-at-0, 3 stuck-at-1
//   run_len_i         last run-relative cycle of the run
//   sig_in_i          fault-free upstream value
//   sig_out_o         possibly corrupted value (combinational)
//   cyc_cnt_o         current run-relative cycle
//   inj_active_o      fault applied to sig_out_o this cycle (combinational)
//   fault_hit_o       sticky: fault applied at least once this run
//   cfg_err_o         latched tgt_bit >= WIDTH
//   done_o            run complete, held while in DONE
module fault_inject_ctrl #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 64,
  parameter int unsigned BIT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] tgt_cycle_i,
  input  logic [BIT_W-1:0] tgt_bit_i,
  input  logic [1:0]       fault_type_i,
  input  logic [CNT_W-1:0] run_len_i,
  input  logic [WIDTH-1:0] sig_in_i,
  output logic [WIDTH-1:0] sig_out_o,
  output logic [CNT_W-1:0] cyc_cnt_o,
  output logic             inj_active_o,
  output logic             fault_hit_o,
  output logic             cfg_err_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [1:0] FT_NONE = 2'd0;
  localparam logic [1:0] FT_FLIP = 2'd1;
  localparam logic [1:0] FT_SA0  = 2'd2;
  localparam logic [1:0] FT_SA1  = 2'd3;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   cyc_cnt_q,   cyc_cnt_d;
  logic [CNT_W-1:0]   tgt_cycle_q, tgt_cycle_d;
  logic [BIT_W-1:0]   tgt_bit_q,   tgt_bit_d;
  logic [1:0]         ftype_q,     ftype_d;
  logic [CNT_W-1:0]   run_len_q,   run_len_d;
  logic               hit_q,       hit_d;
  logic               cfg_err_q,   cfg_err_d;
  logic               done_q,      done_d;

  logic [WIDTH-1:0]   mask_c;
  logic               window_c;
  logic               inj_c;
  logic               cfg_err_new_c;

  // Target bit is out of range only for non-power-of-two WIDTH.
  assign cfg_err_new_c = (32'(tgt_bit_i) >= WIDTH);

  // One-hot corruption mask; an invalid target disables injection entirely.
  assign mask_c = cfg_err_q ? '0 : (WIDTH'(1) << tgt_bit_q);

  // Fault window: a single cycle for a flip, open-ended for stuck-at types.
  always_comb begin
    window_c = 1'b0;
    unique case (ftype_q)
      FT_NONE: window_c = 1'b0;
      FT_FLIP: window_c = (cyc_cnt_q == tgt_cycle_q);
      FT_SA0,
      FT_SA1:  window_c = (cyc_cnt_q >= tgt_cycle_q);
      default: window_c = 1'b0;
    endcase
  end

  assign inj_c = (state_q == ST_RUN) && (mask_c != '0) && window_c;

  // Corrupted data path.
  always_comb begin
    sig_out_o = sig_in_i;
    if (inj_c) begin
      unique case (ftype_q)
        FT_FLIP: sig_out_o = sig_in_i ^ mask_c;
        FT_SA0:  sig_out_o = sig_in_i & ~mask_c;
        FT_SA1:  sig_out_o = sig_in_i | mask_c;
        default: sig_out_o = sig_in_i;
      endcase
    end
  end

  // Next-state logic for the run FSM and its datapath registers.
  always_comb begin
    state_d     = state_q;
    cyc_cnt_d   = cyc_cnt_q;
    tgt_cycle_d = tgt_cycle_q;
    tgt_bit_d   = tgt_bit_q;
    ftype_d     = ftype_q;
    run_len_d   = run_len_q;
    hit_d       = hit_q;
    cfg_err_d   = cfg_err_q;
    done_d      = done_q;
    unique case (state_q)
      ST_IDLE,
      ST_DONE: begin
        if (start_i) begin
          tgt_cycle_d = tgt_cycle_i;
          tgt_bit_d   = tgt_bit_i;
          ftype_d     = fault_type_i;
          run_len_d   = run_len_i;
          cfg_err_d   = cfg_err_new_c;
          cyc_cnt_d   = '0;
          hit_d       = 1'b0;
          done_d      = 1'b0;
          state_d     = ST_RUN;
        end
      end
      ST_RUN: begin
        if (inj_c) begin
          hit_d = 1'b1;
        end
        // Compare before incrementing so run_len at the counter maximum never wraps.
        if (cyc_cnt_q == run_len_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          cyc_cnt_d = cyc_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cyc_cnt_q   <= '0;
      tgt_cycle_q <= '0;
      tgt_bit_q   <= '0;
      ftype_q     <= '0;
      run_len_q   <= '0;
      hit_q       <= 1'b0;
      cfg_err_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_cnt_q   <= cyc_cnt_d;
      tgt_cycle_q <= tgt_cycle_d;
      tgt_bit_q   <= tgt_bit_d;
      ftype_q     <= ftype_d;
      run_len_q   <= run_len_d;
      hit_q       <= hit_d;
      cfg_err_q   <= cfg_err_d;
      done_q      <= done_d;
    end
  end

  assign cyc_cnt_o    = cyc_cnt_q;
  assign inj_active_o = inj_c;
  assign fault_hit_o  = hit_q;
  assign cfg_err_o    = cfg_err_q;
  assign done_o       = done_q;

endmodule

// File: tb/tb_fault_inject_ctrl.sv
// Bench for fault_inject_ctrl: a 64-bit instance (a_*) and a 48-bit instance
// with an 8-bit counter (b_*), both checked every cycle against a run-level
// reference model, plus a vector table and directed corner sequences.
module tb_fault_inject_ctrl;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  // 64-bit instance signals
  logic        a_rst, a_start;
  logic [63:0] a_tgt, a_len, a_sig, a_sig_out, a_cyc;
  logic [5:0]  a_bit;
  logic [1:0]  a_typ;
  logic        a_inj, a_hit, a_err, a_done;

  // 48-bit instance signals
  logic        b_rst, b_start;
  logic [7:0]  b_tgt, b_len, b_cyc;
  logic [47:0] b_sig, b_sig_out;
  logic [5:0]  b_bit;
  logic [1:0]  b_typ;
  logic        b_inj, b_hit, b_err, b_done;

  fault_inject_ctrl u_dut_a (
    .clk_i(clk), .rst_i(a_rst), .start_i(a_start), .tgt_cycle_i(a_tgt),
    .tgt_bit_i(a_bit), .fault_type_i(a_typ), .run_len_i(a_len), .sig_in_i(a_sig),
    .sig_out_o(a_sig_out), .cyc_cnt_o(a_cyc), .inj_active_o(a_inj),
    .fault_hit_o(a_hit), .cfg_err_o(a_err), .done_o(a_done)
  );

  fault_inject_ctrl #(.WIDTH(48), .CNT_W(8)) u_dut_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .tgt_cycle_i(b_tgt),
    .tgt_bit_i(b_bit), .fault_type_i(b_typ), .run_len_i(b_len), .sig_in_i(b_sig),
    .sig_out_o(b_sig_out), .cyc_cnt_o(b_cyc), .inj_active_o(b_inj),
    .fault_hit_o(b_hit), .cfg_err_o(b_err), .done_o(b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Run-level model: phase 0 idle, 1 running at relative cycle k, 2 finished.
  typedef struct {
    int          phase;
    logic [63:0] k, tgt, len;
    int unsigned bitx;
    logic [1:0]  typ;
    bit          hit, err;
  } mdl_t;

  mdl_t ma, mb;

  function automatic bit m_inj(mdl_t m);
    if (m.phase != 1 || m.err) return 1'b0;
    if (m.typ == 2'd1) return (m.k == m.tgt);
    if (m.typ >= 2'd2) return (m.k >= m.tgt);
    return 1'b0;
  endfunction

  function automatic logic [63:0] m_sig(mdl_t m, logic [63:0] sig);
    logic [63:0] r;
    r = sig;
    if (m_inj(m)) begin
      case (m.typ)
        2'd1:    r[m.bitx] = ~sig[m.bitx];
        2'd2:    r[m.bitx] = 1'b0;
        default: r[m.bitx] = 1'b1;
      endcase
    end
    return r;
  endfunction

  function automatic mdl_t m_next(mdl_t m, bit rst, bit start, logic [63:0] tgt,
                                  int unsigned bitx, logic [1:0] typ,
                                  logic [63:0] len, int unsigned w);
    mdl_t r;
    r = m;
    if (rst) begin
      r.phase = 0; r.k = 0; r.tgt = 0; r.len = 0; r.bitx = 0;
      r.typ = 0; r.hit = 0; r.err = 0;
    end else if (start && m.phase != 1) begin
      r.phase = 1; r.k = 0; r.tgt = tgt; r.len = len; r.bitx = bitx;
      r.typ = typ; r.hit = 0; r.err = (bitx >= w);
    end else if (m.phase == 1) begin
      if (m_inj(m)) r.hit = 1'b1;
      if (m.k == m.len) r.phase = 2;
      else r.k = m.k + 64'd1;
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare both instances against the model, away from the active edge.
  task automatic check_cycle();
    @(negedge clk);
    chk("a_sig_out", a_sig_out, m_sig(ma, a_sig));
    chk("a_cyc_cnt", a_cyc, ma.k);
    chk("a_inj",     64'(a_inj),  64'(m_inj(ma)));
    chk("a_hit",     64'(a_hit),  64'(ma.hit));
    chk("a_cfg_err", 64'(a_err),  64'(ma.err));
    chk("a_done",    64'(a_done), 64'(ma.phase == 2));
    chk("b_sig_out", 64'(b_sig_out), m_sig(mb, 64'(b_sig)));
    chk("b_cyc_cnt", 64'(b_cyc), mb.k);
    chk("b_inj",     64'(b_inj),  64'(m_inj(mb)));
    chk("b_hit",     64'(b_hit),  64'(mb.hit));
    chk("b_cfg_err", 64'(b_err),  64'(mb.err));
    chk("b_done",    64'(b_done), 64'(mb.phase == 2));
  endtask

  task automatic advance();
    ma = m_next(ma, a_rst, a_start, a_tgt, int'(a_bit), a_typ, a_len, 64);
    mb = m_next(mb, b_rst, b_start, 64'(b_tgt), int'(b_bit), b_typ, 64'(b_len), 48);
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    check_cycle();
    advance();
  endtask

  // Start a run on the 64-bit instance and follow it to DONE.
  task automatic run_a(input logic [63:0] tgt, input int unsigned bitx, input logic [1:0] typ,
                       input logic [63:0] len, input logic [63:0] sig, input logic [63:0] inj_val,
                       output int n, output logic [63:0] fin, output bit seen, output bit hit);
    a_start = 1'b1; a_tgt = tgt; a_bit = 6'(bitx); a_typ = typ; a_len = len; a_sig = sig;
    tick();
    a_start = 1'b0;
    n = 0; fin = '0; seen = 1'b0; hit = 1'b0;
    for (int c = 0; c < 64 && !seen; c++) begin
      check_cycle();
      if (a_inj) begin
        n++;
        chk("a_inj_value", a_sig_out, inj_val);
      end
      if (a_done) begin
        seen = 1'b1; fin = a_cyc; hit = a_hit;
      end
      advance();
    end
    chk("a_run_done_seen", 64'(seen), 64'd1);
  endtask

  task automatic run_b(input logic [7:0] tgt, input int unsigned bitx, input logic [1:0] typ,
                       input logic [7:0] len, input logic [47:0] sig,
                       output int n, output logic [63:0] fin, output bit hit, output bit err);
    bit seen;
    b_start = 1'b1; b_tgt = tgt; b_bit = 6'(bitx); b_typ = typ; b_len = len; b_sig = sig;
    tick();
    b_start = 1'b0;
    n = 0; fin = '0; seen = 1'b0; hit = 1'b0; err = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      check_cycle();
      if (b_inj) n++;
      if (b_done) begin
        seen = 1'b1; fin = 64'(b_cyc); hit = b_hit; err = b_err;
      end
      advance();
    end
    chk("b_run_done_seen", 64'(seen), 64'd1);
  endtask

  typedef struct {
    logic [63:0] tgt;
    int unsigned bitx;
    logic [1:0]  typ;
    logic [63:0] len;
    logic [63:0] sig;
    int          n_inj;
    logic [63:0] inj_val;
    logic [63:0] fin;
    bit          hit;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int          n;
    logic [63:0] fin;
    bit          seen, hit, err;

    vecs[0] = '{64'd5,  3,  2'd1, 64'd10, 64'd0,  1, 64'h8, 64'd10, 1'b1};
    vecs[1] = '{64'd2,  63, 2'd3, 64'd6,  64'd0,  5, 64'h8000_0000_0000_0000, 64'd6, 1'b1};
    vecs[2] = '{64'd20, 3,  2'd1, 64'd10, 64'd0,  0, 64'd0, 64'd10, 1'b0};
    vecs[3] = '{64'd0,  0,  2'd0, 64'd3,  64'h1234, 0, 64'd0, 64'd3, 1'b0};
    vecs[4] = '{64'd0,  0,  2'd2, 64'd4,  64'hFFFF_FFFF_FFFF_FFFF, 5,
                64'hFFFF_FFFF_FFFF_FFFE, 64'd4, 1'b1};
    vecs[5] = '{64'd0,  0,  2'd1, 64'd0,  64'd5,  1, 64'd4, 64'd0, 1'b1};

    a_rst = 1'b1; a_start = 1'b0; a_tgt = '0; a_bit = '0; a_typ = '0; a_len = '0;
    a_sig = 64'hDEAD_BEEF_0BAD_F00D;
    b_rst = 1'b1; b_start = 1'b0; b_tgt = '0; b_bit = '0; b_typ = '0; b_len = '0;
    b_sig = 48'hABCD_1234_5678;
    @(posedge clk);
    #1;
    ma = m_next(ma, 1'b1, 1'b0, '0, 0, '0, '0, 64);
    mb = m_next(mb, 1'b1, 1'b0, '0, 0, '0, '0, 48);
    tick();
    a_rst = 1'b0; b_rst = 1'b0;
    check_cycle();
    chk("reset_sig_out", a_sig_out, 64'hDEAD_BEEF_0BAD_F00D);
    chk("reset_inj", 64'(a_inj), 64'd0);
    advance();

    // Vector table: each entry is a complete run from start to DONE.
    for (int i = 0; i < 6; i++) begin
      run_a(vecs[i].tgt, vecs[i].bitx, vecs[i].typ, vecs[i].len, vecs[i].sig,
            vecs[i].inj_val, n, fin, seen, hit);
      chk($sformatf("vec%0d_inj_count", i), 64'(n), 64'(vecs[i].n_inj));
      chk($sformatf("vec%0d_final_cyc", i), fin, vecs[i].fin);
      chk($sformatf("vec%0d_fault_hit", i), 64'(hit), 64'(vecs[i].hit));
    end

    // Reset in the middle of a stuck-at-0 run.
    a_start = 1'b1; a_tgt = 64'd0; a_bit = 6'd7; a_typ = 2'd2; a_len = 64'd10;
    a_sig = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 4; c++) tick();
    a_rst = 1'b1;
    check_cycle();
    chk("midrst_cyc_before", a_cyc, 64'd4);
    chk("midrst_sig_before", a_sig_out, 64'hFFFF_FFFF_FFFF_FF7F);
    advance();
    a_rst = 1'b0;
    check_cycle();
    chk("midrst_cyc_after", a_cyc, 64'd0);
    chk("midrst_done_after", 64'(a_done), 64'd0);
    chk("midrst_sig_after", a_sig_out, 64'hFFFF_FFFF_FFFF_FFFF);
    advance();

    // start while running must be ignored.
    a_start = 1'b1; a_tgt = 64'd3; a_bit = 6'd1; a_typ = 2'd1; a_len = 64'd10; a_sig = 64'd0;
    tick();
    a_start = 1'b0;
    for (int c = 0; c < 3; c++) tick();
    a_start = 1'b1; a_tgt = 64'd7; a_bit = 6'd5; a_len = 64'd2;
    check_cycle();
    chk("ignstart_inj_at3", a_sig_out, 64'h2);
    advance();
    a_start = 1'b0;
    seen = 1'b0; fin = '0; hit = 1'b0;
    for (int c = 0; c < 32 && !seen; c++) begin
      check_cycle();
      if (a_done) begin
        seen = 1'b1; fin = a_cyc; hit = a_hit;
      end
      advance();
    end
    chk("ignstart_final_cyc", fin, 64'd10);
    chk("ignstart_hit", 64'(hit), 64'd1);

    // rst wins over start in the same cycle.
    a_rst = 1'b1; a_start = 1'b1;
    tick();
    a_rst = 1'b0; a_start = 1'b0;
    check_cycle();
    chk("rstprio_done", 64'(a_done), 64'd0);
    chk("rstprio_cyc", a_cyc, 64'd0);
    advance();
    tick();

    // Out-of-range target bit on the 48-bit instance.
    run_b(8'd0, 50, 2'd3, 8'd5, 48'h0F0F_0000_1234, n, fin, hit, err);
    chk("cfgerr_flag", 64'(err), 64'd1);
    chk("cfgerr_inj_count", 64'(n), 64'd0);
    chk("cfgerr_hit", 64'(hit), 64'd0);

    // Maximum run length on an 8-bit counter must not wrap.
    run_b(8'd250, 47, 2'd1, 8'd255, 48'd0, n, fin, hit, err);
    chk("maxlen_final_cyc", fin, 64'd255);
    chk("maxlen_inj_count", 64'(n), 64'd1);
    chk("maxlen_hit", 64'(hit), 64'd1);

    // Random traffic on both instances against the model.
    for (int c = 0; c < 2000; c++) begin
      a_rst   = ($urandom_range(63) == 0);
      a_start = ($urandom_range(7) == 0);
      a_tgt   = 64'($urandom_range(15));
      a_bit   = 6'($urandom);
      a_typ   = 2'($urandom);
      a_len   = 64'($urandom_range(15));
      a_sig   = {$urandom, $urandom};
      b_rst   = ($urandom_range(63) == 0);
      b_start = ($urandom_range(7) == 0);
      b_tgt   = 8'($urandom_range(15));
      b_bit   = 6'($urandom);
      b_typ   = 2'($urandom);
      b_len   = 8'($urandom_range(15));
      b_sig   = 48'({$urandom, $urandom});
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
